conv_tile_scheduler: RTL

// Top-level sequencer for the conv datapath: input/weight double buffers, read address gens, systolic array, ofmap accumulator.
// - Accepts one layer config, then per output tile: bank switch, weight preload, ifmap stream, skew flush, ofmap drain.
// - Emits the enable/strobe pattern the datapath consumes; owns no data, only counters and a state machine.

---
 rtl/conv_tile_scheduler_pkg.sv | 39 +++
 rtl/conv_tile_scheduler_if.sv | 50 +++++
 rtl/conv_tile_scheduler_loop_nest_cnt.sv | 53 +++++
 rtl/conv_tile_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/conv_tile_scheduler_pkg.sv
// ============================================================================
// Package  : conv_tile_scheduler_pkg
// Brief    : Shared types and helpers for the conv tile scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_tile_scheduler_pkg;

  localparam int c_cnt_w = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BANKS = 3'd1,
    LOAD_W     = 3'd2,
    STREAM     = 3'd3,
    FLUSH      = 3'd4,
    DRAIN      = 3'd5
  } sched_state_t;

  // Fields hold the last index of each loop (configured value minus one)
  typedef struct packed {
    logic [c_cnt_w-1:0] ox0;
    logic [c_cnt_w-1:0] oy0;
    logic [c_cnt_w-1:0] fx;
    logic [c_cnt_w-1:0] fy;
    logic [c_cnt_w-1:0] ic1;
    logic [c_cnt_w-1:0] oc1;
    logic [c_cnt_w-1:0] tiles;
  } conv_cfg_t;

  // A zero count is illegal and behaves as a count of one
  function automatic logic [c_cnt_w-1:0] cfg_limit(input logic [c_cnt_w-1:0] v);
    return (v == '0) ? '0 : v - c_cnt_w'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_tile_scheduler_if.sv
// ============================================================================
// Interface : conv_tile_scheduler_if
// Brief     : Config, bank, strobe and ofmap handshake bundle of the scheduler.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_tile_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             cfg_vld;
  logic             cfg_rdy;
  logic [CNT_W-1:0] cfg_ox0;
  logic [CNT_W-1:0] cfg_oy0;
  logic [CNT_W-1:0] cfg_fx;
  logic [CNT_W-1:0] cfg_fy;
  logic [CNT_W-1:0] cfg_ic1;
  logic [CNT_W-1:0] cfg_oc1;
  logic [CNT_W-1:0] cfg_tiles;
  logic             in_bank_full;
  logic             wt_bank_full;
  logic             in_switch_banks;
  logic             wt_switch_banks;
  logic             wt_ren;
  logic             arr_weight_we;
  logic             in_ren;
  logic             arr_enable;
  logic             acc_clear;
  logic             acc_we;
  logic             ofmap_vld;
  logic             ofmap_rdy;
  logic             done;

  modport master (
    input  cfg_vld, cfg_ox0, cfg_oy0, cfg_fx, cfg_fy, cfg_ic1, cfg_oc1, cfg_tiles,
    input  in_bank_full, wt_bank_full, ofmap_rdy,
    output cfg_rdy, in_switch_banks, wt_switch_banks, wt_ren, arr_weight_we,
    output in_ren, arr_enable, acc_clear, acc_we, ofmap_vld, done
  );

  modport slave (
    output cfg_vld, cfg_ox0, cfg_oy0, cfg_fx, cfg_fy, cfg_ic1, cfg_oc1, cfg_tiles,
    output in_bank_full, wt_bank_full, ofmap_rdy,
    input  cfg_rdy, in_switch_banks, wt_switch_banks, wt_ren, arr_weight_we,
    input  in_ren, arr_enable, acc_clear, acc_we, ofmap_vld, done
  );

endinterface

`default_nettype wire

// File: rtl/conv_tile_scheduler_loop_nest_cnt.sv
// ============================================================================
// Module   : conv_tile_scheduler_loop_nest_cnt
// Brief    : N-level wrap counter; level 0 is innermost, each level carries
//            into the next when it wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_tile_scheduler_loop_nest_cnt #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic [N-1:0][W-1:0] limit,
  output logic [N-1:0]        last,
  output logic [N-1:0]        zero,
  output logic                all_last
);

  logic [N-1:0] w_carry;

  assign w_carry[0] = inc;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_level
      logic [W-1:0] r_cnt;

      assign last[i] = (r_cnt == limit[i]);
      assign zero[i] = (r_cnt == '0);

      if (i > 0) begin : g_carry
        assign w_carry[i] = w_carry[i-1] & last[i-1];
      end

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          r_cnt <= '0;
        end else if (w_carry[i]) begin
          r_cnt <= last[i] ? '0 : r_cnt + W'(1);
        end
      end
    end
  endgenerate

  assign all_last = &last;

endmodule

`default_nettype wire

// File: rtl/conv_tile_scheduler.sv
// ============================================================================
// Module   : conv_tile_scheduler
// Brief    : Layer/tile sequencer emitting the enable and strobe pattern for the
//            conv datapath (bank swap, weight preload, stream, flush, drain).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_tile_scheduler
  import conv_tile_scheduler_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int CNT_W        = c_cnt_w  // must equal c_cnt_w (config struct width)
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_tile_scheduler_if.master  bus
);

  localparam int c_ph_w = (ARRAY_HEIGHT + ARRAY_WIDTH > 2) ?
                          $clog2(ARRAY_HEIGHT + ARRAY_WIDTH - 1) : 1;
  localparam logic [c_ph_w-1:0] c_load_last  = c_ph_w'(ARRAY_HEIGHT - 1);
  localparam logic [c_ph_w-1:0] c_flush_last = c_ph_w'(ARRAY_HEIGHT + ARRAY_WIDTH - 2);

  sched_state_t            r_state;
  sched_state_t            w_state_nxt;
  conv_cfg_t               r_cfg;
  logic [c_ph_w-1:0]       r_phase;
  logic [ARRAY_HEIGHT-1:0] r_ren_pipe;
  logic                    r_done;

  logic w_cfg_rdy, w_cfg_load, w_cnt_clr, w_done_set;
  logic w_in_sw, w_wt_sw, w_wt_ren, w_in_ren, w_arr_en, w_ofmap_vld;
  logic w_inner_inc, w_outer_inc, w_pix_inc;

  logic [2:0][CNT_W-1:0] w_inner_lim;
  logic [1:0][CNT_W-1:0] w_outer_lim;
  logic [1:0][CNT_W-1:0] w_pix_lim;
  logic [2:0]            w_inner_last, w_inner_zero;
  logic [1:0]            w_outer_last, w_outer_zero;
  logic [1:0]            w_pix_last, w_pix_zero;
  logic                  w_inner_all_last, w_outer_all_last, w_pix_all_last;
  logic                  w_first_tile, w_acc_we;
  logic                  w_unused;

  assign w_inner_lim  = {r_cfg.ic1, r_cfg.fy, r_cfg.fx};
  assign w_outer_lim  = {r_cfg.tiles, r_cfg.oc1};
  assign w_pix_lim    = {r_cfg.oy0, r_cfg.ox0};
  assign w_first_tile = w_outer_zero[1];

  conv_tile_scheduler_loop_nest_cnt #(.N(3), .W(CNT_W)) u_inner (
    .clk(clk), .rst(rst), .clr(w_cnt_clr), .inc(w_inner_inc), .limit(w_inner_lim),
    .last(w_inner_last), .zero(w_inner_zero), .all_last(w_inner_all_last)
  );

  conv_tile_scheduler_loop_nest_cnt #(.N(2), .W(CNT_W)) u_outer (
    .clk(clk), .rst(rst), .clr(w_cnt_clr), .inc(w_outer_inc), .limit(w_outer_lim),
    .last(w_outer_last), .zero(w_outer_zero), .all_last(w_outer_all_last)
  );

  // Output pixel counter, shared by STREAM (one per cycle) and DRAIN (one per transfer)
  conv_tile_scheduler_loop_nest_cnt #(.N(2), .W(CNT_W)) u_pix (
    .clk(clk), .rst(rst), .clr(w_cnt_clr), .inc(w_pix_inc), .limit(w_pix_lim),
    .last(w_pix_last), .zero(w_pix_zero), .all_last(w_pix_all_last)
  );

  assign w_unused = &{w_inner_last, w_pix_last, w_pix_zero, w_outer_zero[0], w_outer_all_last};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_phase    <= '0;
      r_ren_pipe <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_set;
      r_ren_pipe <= (r_ren_pipe << 1) | ARRAY_HEIGHT'(w_in_ren);
      if (w_cfg_load) begin
        r_cfg <= '{ox0:   cfg_limit(bus.cfg_ox0),
                   oy0:   cfg_limit(bus.cfg_oy0),
                   fx:    cfg_limit(bus.cfg_fx),
                   fy:    cfg_limit(bus.cfg_fy),
                   ic1:   cfg_limit(bus.cfg_ic1),
                   oc1:   cfg_limit(bus.cfg_oc1),
                   tiles: cfg_limit(bus.cfg_tiles)};
      end
      if (r_state == LOAD_W) begin
        r_phase <= (r_phase == c_load_last) ? '0 : r_phase + c_ph_w'(1);
      end else if (r_state == FLUSH) begin
        r_phase <= (r_phase == c_flush_last) ? '0 : r_phase + c_ph_w'(1);
      end else begin
        r_phase <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_rdy   = 1'b0;
    w_cfg_load  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_done_set  = 1'b0;
    w_in_sw     = 1'b0;
    w_wt_sw     = 1'b0;
    w_wt_ren    = 1'b0;
    w_in_ren    = 1'b0;
    w_arr_en    = 1'b0;
    w_ofmap_vld = 1'b0;
    w_inner_inc = 1'b0;
    w_outer_inc = 1'b0;
    w_pix_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_rdy = 1'b1;
        if (bus.cfg_vld) begin
          w_cfg_load  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = WAIT_BANKS;
        end
      end
      WAIT_BANKS: begin
        // Weights are loaded once per layer, so only the first tile waits on them
        if (bus.in_bank_full && (!w_first_tile || bus.wt_bank_full)) begin
          w_in_sw     = 1'b1;
          w_wt_sw     = w_first_tile;
          w_state_nxt = LOAD_W;
        end
      end
      LOAD_W: begin
        w_wt_ren = 1'b1;
        if (r_phase == c_load_last) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_in_ren  = 1'b1;
        w_arr_en  = 1'b1;
        w_pix_inc = 1'b1;
        if (w_pix_all_last) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_arr_en = 1'b1;
        if (r_phase == c_flush_last) begin
          w_inner_inc = 1'b1;
          w_state_nxt = w_inner_all_last ? DRAIN : LOAD_W;
        end
      end
      DRAIN: begin
        w_ofmap_vld = 1'b1;
        if (bus.ofmap_rdy) begin
          w_pix_inc = 1'b1;
          if (w_pix_all_last) begin
            w_outer_inc = 1'b1;
            if (!w_outer_last[0]) begin
              w_state_nxt = LOAD_W;
            end else if (!w_outer_last[1]) begin
              w_state_nxt = WAIT_BANKS;
            end else begin
              w_done_set  = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Psum for a streamed pixel reaches the accumulator after read latency plus row skew
  assign w_acc_we = r_ren_pipe[ARRAY_HEIGHT-1];

  assign bus.cfg_rdy         = w_cfg_rdy;
  assign bus.in_switch_banks = w_in_sw;
  assign bus.wt_switch_banks = w_wt_sw;
  assign bus.wt_ren          = w_wt_ren;
  assign bus.arr_weight_we   = w_wt_ren;
  assign bus.in_ren          = w_in_ren;
  assign bus.arr_enable      = w_arr_en;
  assign bus.acc_we          = w_acc_we;
  assign bus.acc_clear       = w_acc_we & (&w_inner_zero);
  assign bus.ofmap_vld       = w_ofmap_vld;
  assign bus.done            = r_done;

endmodule

`default_nettype wire
